// File: rtl/bp_io_cmd_wormhole_serializer_pkg.sv
// Shared types and sizing helpers for the IO command wormhole serializer and its
// matching deserializer.
package bp_io_cmd_wormhole_serializer_pkg;

  localparam int unsigned io_noc_flit_width_lp = 64;
  localparam int unsigned io_noc_cord_width_lp = 8;
  localparam int unsigned io_noc_len_width_lp  = 4;
  localparam int unsigned io_hdr_width_lp      = 96;
  localparam int unsigned io_data_width_lp     = 512;

  typedef enum logic [1:0] {
    e_ready = 2'd0,
    e_hdr   = 2'd1,
    e_data  = 2'd2
  } state_e;

  // Wormhole header image at the default IO NoC widths, cord in the LSBs
  typedef struct packed {
    logic [io_hdr_width_lp-1:0]     hdr;
    logic [io_noc_len_width_lp-1:0] len;
    logic [io_noc_cord_width_lp-1:0] cord;
  } bp_io_wormhole_header_s;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  function automatic int unsigned hdr_flits(input int unsigned cord_width,
                                            input int unsigned len_width,
                                            input int unsigned hdr_width,
                                            input int unsigned flit_width);
    return ceil_div(cord_width + len_width + hdr_width, flit_width);
  endfunction

  function automatic int unsigned max_data_flits(input int unsigned data_width,
                                                 input int unsigned flit_width);
    return data_width / flit_width;
  endfunction

endpackage

// File: rtl/bp_io_cmd_wormhole_serializer_counter.sv
// Flit index counter: synchronous clear has priority over increment.
module bp_io_cmd_wormhole_serializer_counter #(
  parameter int unsigned width_p = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               up,
  output logic [width_p-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (up) begin
      count <= count + width_p'(1);
    end
  end

endmodule

// File: rtl/bp_io_cmd_wormhole_serializer.sv
// Serializes one IO command message (header + optional payload) into a wormhole packet
// on a ready_and flit link; single-message buffer, back-to-back packets without bubbles.
module bp_io_cmd_wormhole_serializer
  import bp_io_cmd_wormhole_serializer_pkg::*;
#(
  parameter int unsigned flit_width_p = io_noc_flit_width_lp,
  parameter int unsigned cord_width_p = io_noc_cord_width_lp,
  parameter int unsigned len_width_p  = io_noc_len_width_lp,
  parameter int unsigned hdr_width_p  = io_hdr_width_lp,
  parameter int unsigned data_width_p = io_data_width_lp
) (
  input  logic                    io_clk_i,
  input  logic                    io_reset_i,
  input  logic [hdr_width_p-1:0]  msg_header_i,
  input  logic [data_width_p-1:0] msg_data_i,
  input  logic [2:0]              msg_size_i,
  input  logic                    msg_has_data_i,
  input  logic [cord_width_p-1:0] msg_cord_i,
  input  logic                    msg_v_i,
  output logic                    msg_ready_and_o,
  output logic [flit_width_p-1:0] flit_o,
  output logic                    flit_v_o,
  input  logic                    flit_ready_and_i
);

  localparam int unsigned hdr_flits_lp      = hdr_flits(cord_width_p, len_width_p, hdr_width_p, flit_width_p);
  localparam int unsigned max_data_flits_lp = max_data_flits(data_width_p, flit_width_p);
  localparam int unsigned total_flits_lp    = hdr_flits_lp + max_data_flits_lp;
  localparam int unsigned hdr_img_width_lp  = hdr_flits_lp * flit_width_p;
  localparam int unsigned max_size_lp       = $clog2(data_width_p / 8);

  if ((data_width_p % flit_width_p) != 0) begin : g_data_width_check
    $error("data_width_p must be a multiple of flit_width_p");
  end
  if (total_flits_lp - 1 >= (2 ** len_width_p)) begin : g_len_width_check
    $error("len_width_p too narrow for the largest packet");
  end

  state_e state, state_n;

  logic [len_width_p-1:0] cnt;
  logic [len_width_p-1:0] len_r;
  logic [len_width_p-1:0] len_c;
  logic                   cnt_clear;
  logic                   cnt_up;

  logic [total_flits_lp-1:0][flit_width_p-1:0] pkt_r;
  logic [hdr_img_width_lp-1:0]                 hdr_img;
  logic [data_width_p-1:0]                     data_masked;
  logic [31:0]                                 payload_bits;
  logic [31:0]                                 data_flits;

  logic handshake;
  logic accept;
  logic last_flit;
  logic hdr_last;

  assign flit_v_o        = (state != e_ready);
  assign handshake       = flit_v_o & flit_ready_and_i;
  assign last_flit       = (cnt == len_r);
  assign hdr_last        = (cnt == len_width_p'(hdr_flits_lp - 1));
  // Ready reaches back through the final handshake so packets run back to back
  assign msg_ready_and_o = ~io_reset_i & ((state == e_ready) | (handshake & last_flit));
  assign accept          = msg_v_i & msg_ready_and_o;

  // Packet length and zero-padded payload, evaluated at accept time
  always_comb begin
    payload_bits = 32'd8 << msg_size_i;
    data_flits   = payload_bits / 32'(flit_width_p);
    if (data_flits == 32'd0) begin
      data_flits = 32'd1;
    end
    if (data_flits > 32'(max_data_flits_lp)) begin
      data_flits = 32'(max_data_flits_lp);
    end
    if (!msg_has_data_i) begin
      data_flits = 32'd0;
    end
    len_c = len_width_p'(32'(hdr_flits_lp) + data_flits - 32'd1);
    for (int unsigned i = 0; i < data_width_p; i++) begin
      data_masked[i] = msg_data_i[i] & (i < payload_bits);
    end
  end

  assign hdr_img = hdr_img_width_lp'({msg_header_i, len_c, msg_cord_i});

  always_ff @(posedge io_clk_i) begin
    if (io_reset_i) begin
      state <= e_ready;
      len_r <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        len_r <= len_c;
      end
    end
  end

  // Message buffer holds no control state, so it needs no reset
  always_ff @(posedge io_clk_i) begin
    if (accept) begin
      pkt_r <= {data_masked, hdr_img};
    end
  end

  bp_io_cmd_wormhole_serializer_counter #(
    .width_p(len_width_p)
  ) u_flit_cnt (
    .clk   (io_clk_i),
    .reset (io_reset_i),
    .clear (cnt_clear),
    .up    (cnt_up),
    .count (cnt)
  );

  always_comb begin
    state_n   = state;
    cnt_clear = 1'b0;
    cnt_up    = 1'b0;
    unique case (state)
      e_ready: begin
        if (accept) begin
          state_n   = e_hdr;
          cnt_clear = 1'b1;
        end
      end
      e_hdr, e_data: begin
        if (handshake) begin
          if (last_flit) begin
            state_n   = accept ? e_hdr : e_ready;
            cnt_clear = 1'b1;
          end else begin
            cnt_up = 1'b1;
            if ((state == e_hdr) && hdr_last) begin
              state_n = e_data;
            end
          end
        end
      end
      default: state_n = e_ready;
    endcase
  end

  always_comb begin
    flit_o = '0;
    for (int unsigned i = 0; i < total_flits_lp; i++) begin
      if (cnt == len_width_p'(i)) begin
        flit_o = pkt_r[i];
      end
    end
  end

  always_ff @(posedge io_clk_i) begin
    if (!io_reset_i && accept) begin
      assert (msg_size_i <= 3'(max_size_lp))
        else $error("msg_size_i larger than the payload buffer; packet sent capped");
    end
  end

endmodule

// File: tb/tb_bp_io_cmd_wormhole_serializer.sv
// Directed, table-driven bench for the IO command wormhole serializer.
module tb_bp_io_cmd_wormhole_serializer;
  import bp_io_cmd_wormhole_serializer_pkg::*;

  logic         io_clk_i = 1'b0;
  logic         io_reset_i;
  logic [95:0]  msg_header_i;
  logic [511:0] msg_data_i;
  logic [2:0]   msg_size_i;
  logic         msg_has_data_i;
  logic [7:0]   msg_cord_i;
  logic         msg_v_i;
  logic         msg_ready_and_o;
  logic [63:0]  flit_o;
  logic         flit_v_o;
  logic         flit_ready_and_i;

  always #5 io_clk_i = ~io_clk_i;

  bp_io_cmd_wormhole_serializer dut (
    .io_clk_i         (io_clk_i),
    .io_reset_i       (io_reset_i),
    .msg_header_i     (msg_header_i),
    .msg_data_i       (msg_data_i),
    .msg_size_i       (msg_size_i),
    .msg_has_data_i   (msg_has_data_i),
    .msg_cord_i       (msg_cord_i),
    .msg_v_i          (msg_v_i),
    .msg_ready_and_o  (msg_ready_and_o),
    .flit_o           (flit_o),
    .flit_v_o         (flit_v_o),
    .flit_ready_and_i (flit_ready_and_i)
  );

  typedef struct {
    logic        has_data;
    logic [2:0]  size;
    logic [7:0]  cord;
    logic [95:0] hdr;
    int          pat;
    int          exp_n;
    logic [3:0]  exp_len;
  } vec_t;

  localparam int unsigned num_vecs_lp = 6;

  vec_t        vecs [num_vecs_lp];
  logic [63:0] exp_flits [10];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // 0: byte i = i, 1: single byte A5, 2: byte i = C0 + i
  function automatic logic [511:0] make_data(input int pat);
    logic [511:0] d;
    d = '0;
    for (int i = 0; i < 64; i++) begin
      if (pat == 0) d[8*i +: 8] = 8'(i);
      if (pat == 2) d[8*i +: 8] = 8'(8'hC0 + i);
    end
    if (pat == 1) d[7:0] = 8'hA5;
    return d;
  endfunction

  task automatic build_exp(input vec_t v);
    logic [127:0] img;
    logic [511:0] d;
    img = 128'({v.hdr, v.exp_len, v.cord});
    d   = make_data(v.pat);
    exp_flits[0] = img[63:0];
    exp_flits[1] = img[127:64];
    for (int k = 0; k < 8; k++) begin
      exp_flits[2 + k] = d[64*k +: 64];
    end
  endtask

  task automatic drive_msg(input vec_t v);
    msg_header_i   = v.hdr;
    msg_data_i     = make_data(v.pat);
    msg_size_i     = v.size;
    msg_has_data_i = v.has_data;
    msg_cord_i     = v.cord;
  endtask

  task automatic send(input vec_t v, input string tag);
    @(negedge io_clk_i);
    drive_msg(v);
    msg_v_i = 1'b1;
    #2 check({tag, "_msg_ready"}, 64'(msg_ready_and_o), 64'd1);
    @(posedge io_clk_i);
    #1 msg_v_i = 1'b0;
  endtask

  task automatic collect(input int n, input bit stall, input logic [7:0] cord,
                         input logic [3:0] len, input string tag);
    int          got = 0;
    int          drops = 0;
    int          holds_bad = 0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev = '0;
    for (int c = 0; c < 300 && got < n; c++) begin
      @(negedge io_clk_i);
      flit_ready_and_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #2;
      if (c == 0) check({tag, "_latency_v"}, 64'(flit_v_o), 64'd1);
      if (!flit_v_o) begin
        drops++;
      end else begin
        if (prev_stall && (flit_o !== prev)) holds_bad++;
        if (flit_ready_and_i) begin
          if (got == 0) begin
            check({tag, "_cord"}, 64'(flit_o[7:0]), 64'(cord));
            check({tag, "_len"}, 64'(flit_o[11:8]), 64'(len));
          end
          check($sformatf("%s_flit%0d", tag, got), flit_o, exp_flits[got]);
          got++;
        end
      end
      prev_stall = flit_v_o && !flit_ready_and_i;
      prev       = flit_o;
    end
    check({tag, "_count"}, 64'(got), 64'(n));
    check({tag, "_v_drops"}, 64'(drops), 64'd0);
    check({tag, "_stall_hold"}, 64'(holds_bad), 64'd0);
    @(negedge io_clk_i);
    flit_ready_and_i = 1'b1;
    #2 check({tag, "_idle_after"}, 64'(flit_v_o), 64'd0);
  endtask

  initial begin
    int accepts, got, bubbles, second_at;

    vecs[0] = '{1'b0, 3'd6, 8'h03, 96'h0123_4567_89AB_CDEF_FEDC_BA98, 0, 2,  4'd1};
    vecs[1] = '{1'b1, 3'd6, 8'h05, 96'hDEAD_BEEF_0000_1111_2222_3333, 0, 10, 4'd9};
    vecs[2] = '{1'b1, 3'd0, 8'h0A, 96'h8000_0000_0000_0000_0000_0001, 1, 3,  4'd2};
    vecs[3] = '{1'b1, 3'd3, 8'h7E, 96'hA5A5_5A5A_F0F0_0F0F_1234_5678, 2, 3,  4'd2};
    vecs[4] = '{1'b1, 3'd4, 8'hFF, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 2, 4,  4'd3};
    vecs[5] = '{1'b1, 3'd5, 8'h40, 96'h0000_0000_0000_0000_0000_0000, 0, 6,  4'd5};

    io_reset_i       = 1'b1;
    msg_v_i          = 1'b0;
    flit_ready_and_i = 1'b0;
    drive_msg(vecs[0]);

    repeat (3) @(negedge io_clk_i);
    #2;
    check("reset_flit_v", 64'(flit_v_o), 64'd0);
    check("reset_msg_ready", 64'(msg_ready_and_o), 64'd0);
    io_reset_i = 1'b0;
    @(negedge io_clk_i);
    #2 check("post_reset_msg_ready", 64'(msg_ready_and_o), 64'd1);
    check("post_reset_flit_v", 64'(flit_v_o), 64'd0);

    // Single messages, link always ready
    for (int i = 0; i < num_vecs_lp; i++) begin
      build_exp(vecs[i]);
      send(vecs[i], $sformatf("v%0d", i));
      collect(vecs[i].exp_n, 1'b0, vecs[i].cord, vecs[i].exp_len, $sformatf("v%0d", i));
    end

    // Same 64B message under random backpressure
    build_exp(vecs[1]);
    send(vecs[1], "stall");
    collect(10, 1'b1, vecs[1].cord, vecs[1].exp_len, "stall");

    // Two 64B messages offered continuously: 20 flits, no bubble
    build_exp(vecs[1]);
    @(negedge io_clk_i);
    drive_msg(vecs[1]);
    msg_v_i = 1'b1;
    flit_ready_and_i = 1'b1;
    accepts = 0; got = 0; bubbles = 0; second_at = -1;
    for (int c = 0; c < 60 && got < 20; c++) begin
      #2;
      if (flit_v_o) begin
        check($sformatf("b2b_flit%0d", got), flit_o, exp_flits[got % 10]);
        got++;
      end else if (got > 0) begin
        bubbles++;
      end
      if (msg_v_i && msg_ready_and_o) begin
        accepts++;
        if (accepts == 2) second_at = got;
      end
      @(posedge io_clk_i);
      #1 if (accepts == 2) msg_v_i = 1'b0;
      @(negedge io_clk_i);
    end
    #2;
    check("b2b_count", 64'(got), 64'd20);
    check("b2b_bubbles", 64'(bubbles), 64'd0);
    check("b2b_accepts", 64'(accepts), 64'd2);
    check("b2b_second_accept_at", 64'(second_at), 64'd10);
    check("b2b_idle_after", 64'(flit_v_o), 64'd0);

    // Reset after 4 of 10 flits drops the packet
    build_exp(vecs[1]);
    send(vecs[1], "rst");
    got = 0;
    for (int c = 0; c < 50 && got < 4; c++) begin
      @(negedge io_clk_i);
      flit_ready_and_i = 1'b1;
      #2;
      if (flit_v_o && flit_ready_and_i) begin
        check($sformatf("rst_flit%0d", got), flit_o, exp_flits[got]);
        got++;
      end
    end
    check("rst_pre_count", 64'(got), 64'd4);
    io_reset_i = 1'b1;
    @(negedge io_clk_i);
    #2;
    check("rst_flit_v", 64'(flit_v_o), 64'd0);
    check("rst_msg_ready", 64'(msg_ready_and_o), 64'd0);
    @(negedge io_clk_i);
    io_reset_i = 1'b0;
    build_exp(vecs[2]);
    send(vecs[2], "after_rst");
    collect(3, 1'b0, vecs[2].cord, vecs[2].exp_len, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
